tron_game_ctrl: RTL and testbench
=================================

// Module: tron_game_ctrl
// PURPOSE
//  Round/match sequencer for the two-player light-cycle game. Owns game state, latches
//  player headings from the synchronized PMOD direction pads, paces movement off the
//  VGA frame rate, clears the trace field between rounds and keeps per-player scores.
//  Sits between the input synchronizers and draw_trace/draw_object.
// PARAMETERS
//  FRAMES_PER_MOVE  2   frame_start pulses per move_tick in PLAY (>=1)
//  COUNT_FROM       3   countdown start digit (1..9)
//  FRAMES_PER_COUNT 60  frames per countdown digit (>=1)
//  CRASH_FRAMES     90  frames held in CRASH before next round/game over (>=1)
//  WIN_SCORE        5   round wins ending the match (1..15)
// PORTS
//  clk_40MHz    in   1  pixel clock
//  reset        in   1  async, active-high; whole block
//  start        in   1  synchronized start button level; rising edge used
//  frame_start  in   1  1-cycle pulse per VGA frame
//  p1_pad       in   4  synchronized raw dir {down,up,right,left}
//  p2_pad       in   4  same encoding, player 2
//  p1_crash     in   1  draw_trace: p1 hit a trace/wall (level)
//  p2_crash     in   1  draw_trace: p2 hit a trace/wall (level)
//  p1_dir       out  4  one-hot heading to draw logic; 0 = stopped
//  p2_dir       out  4  same, player 2
//  move_tick    out  1  1-cycle pulse: advance both cycles one step
//  clear_trace  out  1  high for one full frame: wipe trace memory, respawn
//  count_digit  out  4  countdown digit for 7-seg; 0 outside COUNTDOWN
//  p1_score     out  4  round wins, player 1
//  p2_score     out  4  round wins, player 2
//  winner       out  2  00 none, 01 p1, 10 p2, 11 draw (last round result)
//  state_o      out  3  encoded game_state_t for debug LEDs
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; headings p1=RIGHT(0010), p2=LEFT(0001).
//  Encoding: LEFT 0001, RIGHT 0010, UP 0100, DOWN 1000. Pad valid only if exactly one-hot.
//  FSM (all outputs registered):
//   IDLE      : start rise -> CLEAR.
//   CLEAR     : clear_trace=1; headings reload p1=RIGHT, p2=LEFT; winner unchanged;
//               stays until 2nd frame_start after entry (one full frame) -> COUNTDOWN.
//   COUNTDOWN : count_digit=COUNT_FROM, decrement every FRAMES_PER_COUNT frames; on
//               frame completing digit 1 -> PLAY. Pads ignored, crashes ignored.
//   PLAY      : p1_dir/p2_dir = headings (0 in every other state). Frame counter; on
//               frame_start completing FRAMES_PER_MOVE, move_tick=1 next cycle.
//               Any crash high -> CRASH next cycle; move_tick for that cycle suppressed.
//   CRASH     : entry: p1 only -> p2_score+1, winner=10; p2 only -> p1_score+1,
//               winner=01; both same cycle -> draw, winner=11, no score. After
//               CRASH_FRAMES frames: a score==WIN_SCORE -> GAME_OVER else CLEAR.
//   GAME_OVER : outputs frozen; start rise -> scores=0, winner=00 -> CLEAR.
//  Heading update (PLAY only): valid pad stored as pending; exact opposite of the
//   committed heading rejected; same as heading ignored. Pending committed to heading
//   on move_tick, so two presses inside one move step cannot produce a reversal; last
//   valid press before the tick wins. Multi-hot or zero pad: pending unchanged.
//  start held high never retriggers; edge detector reloads to 1 on reset (press held
//   through reset not seen). Scores saturate at WIN_SCORE.
//  Async reset mid-round: immediate IDLE, scores/counters cleared, clear_trace drops.
// STRUCTURE
//  tron_pkg: dir_t (4-bit one-hot consts DIR_NONE/LEFT/RIGHT/UP/DOWN),
//   game_state_t enum (IDLE,CLEAR,COUNTDOWN,PLAY,CRASH,GAME_OVER), function
//   opposite(dir_t), winner encodings.
//  Sub-module frame_counter #(MAX): counts frame_start while en, clr input, done
//   pulse on terminal count; instantiated for move pacing, countdown and crash hold
//   (or one shared instance with reloaded limit).
// TESTING
//  1 reset, start pulse -> CLEAR, clear_trace high exactly frame_start#1..#2, then
//    count_digit 3,2,1 each 60 frames, PLAY; p1_dir=0010, p2_dir=0001.
//  2 PLAY, FRAMES_PER_MOVE=2: move_tick once per 2 frame_starts, 1 cycle after pulse.
//  3 p1 heading RIGHT, pad UP then LEFT within one step -> after tick heading UP;
//    pad LEFT alone -> heading stays RIGHT; pad 0110 -> ignored.
//  4 p1_crash only -> CRASH, p2_score 0->1, winner=10, p1_dir=0, 90 frames -> CLEAR.
//  5 p1_crash and p2_crash same cycle coinciding with tick frame -> no move_tick,
//    winner=11, scores unchanged.
//  6 p2 reaches 5 -> GAME_OVER; start held -> no action; release/press -> scores 0,
//    CLEAR; assert reset mid-COUNTDOWN -> all outputs 0 next edge.

Source files
------------

// File: rtl/tron_game_ctrl_pkg.sv
// Shared types and helpers for the light-cycle round/match sequencer.
// Headings are 4-bit one-hot {down,up,right,left}; zero means stopped.
package tron_game_ctrl_pkg;

  typedef logic [3:0] dir_t;

  localparam dir_t DIR_NONE  = 4'b0000;
  localparam dir_t DIR_LEFT  = 4'b0001;
  localparam dir_t DIR_RIGHT = 4'b0010;
  localparam dir_t DIR_UP    = 4'b0100;
  localparam dir_t DIR_DOWN  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_PLAY      = 3'd3,
    ST_CRASH     = 3'd4,
    ST_GAME_OVER = 3'd5
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_LEFT:  opposite = DIR_RIGHT;
      DIR_RIGHT: opposite = DIR_LEFT;
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      default:   opposite = DIR_NONE;
    endcase
  endfunction

  function automatic logic dir_valid(input dir_t d);
    dir_valid = (d != DIR_NONE) && ((d & (d - 4'd1)) == 4'd0);
  endfunction

  // A press replaces the pending heading unless it is malformed, a reversal
  // of the committed heading, or the committed heading itself.
  function automatic dir_t next_pending(input dir_t pad, input dir_t head, input dir_t pend);
    if (!dir_valid(pad)) begin
      next_pending = pend;
    end else if ((pad == opposite(head)) || (pad == head)) begin
      next_pending = pend;
    end else begin
      next_pending = pad;
    end
  endfunction

endpackage

// File: rtl/tron_game_ctrl_if.sv
// Handshake bundle between the input synchronizers, the sequencer and the draw logic.
interface tron_game_ctrl_if;
  import tron_game_ctrl_pkg::*;

  logic       start;
  logic       frame_start;
  dir_t       p1_pad;
  dir_t       p2_pad;
  logic       p1_crash;
  logic       p2_crash;
  dir_t       p1_dir;
  dir_t       p2_dir;
  logic       move_tick;
  logic       clear_trace;
  logic [3:0] count_digit;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [2:0] state_o;

  modport master (
    output start, frame_start, p1_pad, p2_pad, p1_crash, p2_crash,
    input  p1_dir, p2_dir, move_tick, clear_trace, count_digit,
           p1_score, p2_score, winner, state_o
  );

  modport slave (
    input  start, frame_start, p1_pad, p2_pad, p1_crash, p2_crash,
    output p1_dir, p2_dir, move_tick, clear_trace, count_digit,
           p1_score, p2_score, winner, state_o
  );
endinterface

// File: rtl/tron_game_ctrl_frame_counter.sv
// Counts frame_start pulses while enabled; done fires combinationally on the
// pulse that completes MAX frames so the caller can register its reaction.
module tron_game_ctrl_frame_counter #(
  parameter int MAX = 2
) (
  input  logic clk_40MHz,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  input  logic frame_i,
  output logic done_o
);
  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         term_s;

  assign term_s = (cnt_q == W'(MAX - 1));
  assign done_o = en_i & frame_i & term_s;

  // Next count: wrap at terminal count, hold when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && frame_i) begin
      cnt_d = term_s ? '0 : (cnt_q + W'(1));
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_40MHz or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/tron_game_ctrl.sv
// Round/match sequencer for the two-player light-cycle game: state, headings,
// movement pacing, trace clearing between rounds and scoring. All outputs registered.
module tron_game_ctrl
  import tron_game_ctrl_pkg::*;
#(
  parameter int FRAMES_PER_MOVE  = 2,
  parameter int COUNT_FROM       = 3,
  parameter int FRAMES_PER_COUNT = 60,
  parameter int CRASH_FRAMES     = 90,
  parameter int WIN_SCORE        = 5
) (
  input  logic              clk_40MHz,
  input  logic              reset,
  tron_game_ctrl_if.slave   bus
);
  game_state_t state_q, state_d;
  dir_t        p1_dir_q, p1_dir_d, p2_dir_q, p2_dir_d;
  dir_t        hd1_q, hd1_d, hd2_q, hd2_d;
  dir_t        pend1_q, pend1_d, pend2_q, pend2_d;
  logic        move_tick_q, move_tick_d;
  logic        clear_trace_q, clear_trace_d;
  logic [3:0]  count_digit_q, count_digit_d;
  logic [3:0]  p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic [1:0]  winner_q, winner_d;
  logic        start_q;
  logic        start_rise_s, move_done_s, count_done_s, crash_done_s;
  logic        in_play_s, in_count_s, in_crash_s;

  assign start_rise_s = bus.start & ~start_q;
  assign in_play_s    = (state_q == ST_PLAY);
  assign in_count_s   = (state_q == ST_COUNTDOWN);
  assign in_crash_s   = (state_q == ST_CRASH);

  tron_game_ctrl_frame_counter #(.MAX(FRAMES_PER_MOVE)) u_move (
    .clk_40MHz(clk_40MHz), .reset(reset), .en_i(in_play_s), .clr_i(~in_play_s),
    .frame_i(bus.frame_start), .done_o(move_done_s));

  tron_game_ctrl_frame_counter #(.MAX(FRAMES_PER_COUNT)) u_count (
    .clk_40MHz(clk_40MHz), .reset(reset), .en_i(in_count_s), .clr_i(~in_count_s),
    .frame_i(bus.frame_start), .done_o(count_done_s));

  tron_game_ctrl_frame_counter #(.MAX(CRASH_FRAMES)) u_crash (
    .clk_40MHz(clk_40MHz), .reset(reset), .en_i(in_crash_s), .clr_i(~in_crash_s),
    .frame_i(bus.frame_start), .done_o(crash_done_s));

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    if (s >= 4'(WIN_SCORE)) begin
      score_inc = s;
    end else begin
      score_inc = s + 4'd1;
    end
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    p1_dir_d      = DIR_NONE;
    p2_dir_d      = DIR_NONE;
    move_tick_d   = 1'b0;
    clear_trace_d = 1'b0;
    count_digit_d = 4'd0;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    winner_d      = winner_q;
    hd1_d         = hd1_q;
    hd2_d         = hd2_q;
    pend1_d       = pend1_q;
    pend2_d       = pend2_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise_s) state_d = ST_CLEAR;
        else              state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        hd1_d = DIR_RIGHT; pend1_d = DIR_RIGHT;
        hd2_d = DIR_LEFT;  pend2_d = DIR_LEFT;
        // First frame_start raises the wipe, the second ends it.
        if (bus.frame_start && clear_trace_q) begin
          state_d       = ST_COUNTDOWN;
          count_digit_d = 4'(COUNT_FROM);
        end else if (bus.frame_start) begin
          clear_trace_d = 1'b1;
        end else begin
          clear_trace_d = clear_trace_q;
        end
      end
      ST_COUNTDOWN: begin
        count_digit_d = count_digit_q;
        if (count_done_s && (count_digit_q == 4'd1)) begin
          state_d       = ST_PLAY;
          count_digit_d = 4'd0;
          p1_dir_d      = hd1_q;
          p2_dir_d      = hd2_q;
        end else if (count_done_s) begin
          count_digit_d = count_digit_q - 4'd1;
        end else begin
          count_digit_d = count_digit_q;
        end
      end
      ST_PLAY: begin
        pend1_d = next_pending(bus.p1_pad, hd1_q, pend1_q);
        pend2_d = next_pending(bus.p2_pad, hd2_q, pend2_q);
        if (bus.p1_crash || bus.p2_crash) begin
          state_d = ST_CRASH;
          if (bus.p1_crash && bus.p2_crash) begin
            winner_d = WIN_DRAW;
          end else if (bus.p1_crash) begin
            winner_d   = WIN_P2;
            p2_score_d = score_inc(p2_score_q);
          end else begin
            winner_d   = WIN_P1;
            p1_score_d = score_inc(p1_score_q);
          end
        end else if (move_done_s) begin
          move_tick_d = 1'b1;
          hd1_d       = pend1_d;
          hd2_d       = pend2_d;
          p1_dir_d    = pend1_d;
          p2_dir_d    = pend2_d;
        end else begin
          p1_dir_d = hd1_q;
          p2_dir_d = hd2_q;
        end
      end
      ST_CRASH: begin
        if (crash_done_s && ((p1_score_q == 4'(WIN_SCORE)) || (p2_score_q == 4'(WIN_SCORE)))) begin
          state_d = ST_GAME_OVER;
        end else if (crash_done_s) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_CRASH;
        end
      end
      ST_GAME_OVER: begin
        if (start_rise_s) begin
          state_d    = ST_CLEAR;
          p1_score_d = 4'd0;
          p2_score_d = 4'd0;
          winner_d   = WIN_NONE;
        end else begin
          state_d = ST_GAME_OVER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; start edge detector reloads high so a held press is ignored.
  always_ff @(posedge clk_40MHz or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      p1_dir_q      <= DIR_NONE;
      p2_dir_q      <= DIR_NONE;
      hd1_q         <= DIR_RIGHT;
      hd2_q         <= DIR_LEFT;
      pend1_q       <= DIR_RIGHT;
      pend2_q       <= DIR_LEFT;
      move_tick_q   <= 1'b0;
      clear_trace_q <= 1'b0;
      count_digit_q <= 4'd0;
      p1_score_q    <= 4'd0;
      p2_score_q    <= 4'd0;
      winner_q      <= WIN_NONE;
      start_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      p1_dir_q      <= p1_dir_d;
      p2_dir_q      <= p2_dir_d;
      hd1_q         <= hd1_d;
      hd2_q         <= hd2_d;
      pend1_q       <= pend1_d;
      pend2_q       <= pend2_d;
      move_tick_q   <= move_tick_d;
      clear_trace_q <= clear_trace_d;
      count_digit_q <= count_digit_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      winner_q      <= winner_d;
      start_q       <= bus.start;
    end
  end

  assign bus.p1_dir      = p1_dir_q;
  assign bus.p2_dir      = p2_dir_q;
  assign bus.move_tick   = move_tick_q;
  assign bus.clear_trace = clear_trace_q;
  assign bus.count_digit = count_digit_q;
  assign bus.p1_score    = p1_score_q;
  assign bus.p2_score    = p2_score_q;
  assign bus.winner      = winner_q;
  assign bus.state_o     = state_q;
endmodule

// File: tb/tb_tron_game_ctrl.sv
// Directed bench for tron_game_ctrl with default parameters; frames are 8 clocks long.
module tb_tron_game_ctrl;
  import tron_game_ctrl_pkg::*;

  localparam int FGAP = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  tron_game_ctrl_if bus_if();

  tron_game_ctrl dut (
    .clk_40MHz(clk),
    .reset(reset),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse();
    bus_if.frame_start = 1'b1;
    cyc();
    bus_if.frame_start = 1'b0;
  endtask

  task automatic frame();
    pulse();
    idle(FGAP - 1);
  endtask

  // From CLEAR (wipe not yet raised) through the whole countdown into PLAY.
  task automatic to_play();
    pulse();
    chk("clr_hi", 8'(bus_if.clear_trace), 8'd1);
    idle(FGAP - 1);
    pulse();
    chk("clr_cd", 8'(bus_if.state_o), 8'd2);
    idle(FGAP - 1);
    repeat (179) frame();
    pulse();
    chk("play_st", 8'(bus_if.state_o), 8'd3);
    chk("play_p1", 8'(bus_if.p1_dir), 8'h02);
    chk("play_p2", 8'(bus_if.p2_dir), 8'h01);
  endtask

  initial begin
    logic [7:0] exp_score;
    logic [7:0] exp_state;
    reset = 1'b1;
    bus_if.start = 1'b1;
    bus_if.frame_start = 1'b0;
    bus_if.p1_pad = 4'd0;
    bus_if.p2_pad = 4'd0;
    bus_if.p1_crash = 1'b0;
    bus_if.p2_crash = 1'b0;
    idle(3);
    chk("rst_state", 8'(bus_if.state_o), 8'd0);
    chk("rst_p1dir", 8'(bus_if.p1_dir), 8'd0);
    chk("rst_digit", 8'(bus_if.count_digit), 8'd0);
    chk("rst_win", 8'(bus_if.winner), 8'd0);
    reset = 1'b0;
    idle(3);
    chk("held_start", 8'(bus_if.state_o), 8'd0);
    bus_if.start = 1'b0;
    cyc();
    bus_if.start = 1'b1;
    cyc();
    chk("to_clear", 8'(bus_if.state_o), 8'd1);
    chk("clr_lo0", 8'(bus_if.clear_trace), 8'd0);

    // Clear window and countdown 3,2,1
    pulse();
    chk("clr_on", 8'(bus_if.clear_trace), 8'd1);
    idle(FGAP - 1);
    chk("clr_mid", 8'(bus_if.clear_trace), 8'd1);
    pulse();
    chk("clr_off", 8'(bus_if.clear_trace), 8'd0);
    chk("digit3", 8'(bus_if.count_digit), 8'd3);
    idle(FGAP - 1);
    bus_if.p1_pad = DIR_UP;
    repeat (59) frame();
    bus_if.p1_pad = 4'd0;
    chk("digit3_end", 8'(bus_if.count_digit), 8'd3);
    pulse();
    chk("digit2", 8'(bus_if.count_digit), 8'd2);
    idle(FGAP - 1);
    repeat (59) frame();
    pulse();
    chk("digit1", 8'(bus_if.count_digit), 8'd1);
    idle(FGAP - 1);
    repeat (59) frame();
    chk("cd_hold", 8'(bus_if.state_o), 8'd2);
    pulse();
    chk("play", 8'(bus_if.state_o), 8'd3);
    chk("digit0", 8'(bus_if.count_digit), 8'd0);
    chk("p1_right", 8'(bus_if.p1_dir), 8'h02);
    chk("p2_left", 8'(bus_if.p2_dir), 8'h01);

    // Move pacing: one tick per two frames, one cycle after the pulse
    idle(FGAP - 1);
    pulse();
    chk("tick_f1", 8'(bus_if.move_tick), 8'd0);
    idle(FGAP - 1);
    pulse();
    chk("tick_f2", 8'(bus_if.move_tick), 8'd1);
    chk("cd_pad_ign", 8'(bus_if.p1_dir), 8'h02);
    cyc();
    chk("tick_1cyc", 8'(bus_if.move_tick), 8'd0);
    idle(FGAP - 2);
    pulse();
    chk("tick_f3", 8'(bus_if.move_tick), 8'd0);
    idle(FGAP - 1);
    pulse();
    chk("tick_f4", 8'(bus_if.move_tick), 8'd1);
    idle(FGAP - 1);

    // Heading rules
    bus_if.p1_pad = DIR_LEFT;
    cyc();
    bus_if.p1_pad = 4'd0;
    idle(FGAP - 2);
    pulse();
    idle(FGAP - 1);
    pulse();
    chk("rev_tick", 8'(bus_if.move_tick), 8'd1);
    chk("rev_rej", 8'(bus_if.p1_dir), 8'h02);
    idle(FGAP - 1);
    bus_if.p1_pad = 4'b0110;
    cyc();
    bus_if.p1_pad = 4'd0;
    idle(FGAP - 2);
    pulse();
    idle(FGAP - 1);
    pulse();
    chk("multihot", 8'(bus_if.p1_dir), 8'h02);
    idle(FGAP - 1);
    bus_if.p1_pad = DIR_UP;
    bus_if.p2_pad = DIR_DOWN;
    cyc();
    bus_if.p1_pad = DIR_LEFT;
    bus_if.p2_pad = 4'd0;
    cyc();
    bus_if.p1_pad = 4'd0;
    idle(FGAP - 3);
    pulse();
    chk("pre_tick", 8'(bus_if.p1_dir), 8'h02);
    idle(FGAP - 1);
    pulse();
    chk("p1_up", 8'(bus_if.p1_dir), 8'h04);
    chk("p2_down", 8'(bus_if.p2_dir), 8'h08);
    idle(FGAP - 1);

    // p1 crash alone
    bus_if.p1_crash = 1'b1;
    cyc();
    bus_if.p1_crash = 1'b0;
    chk("crash_st", 8'(bus_if.state_o), 8'd4);
    chk("crash_p2s", 8'(bus_if.p2_score), 8'd1);
    chk("crash_p1s", 8'(bus_if.p1_score), 8'd0);
    chk("crash_win", 8'(bus_if.winner), 8'h2);
    chk("crash_dir", 8'(bus_if.p1_dir), 8'd0);
    idle(FGAP - 1);
    repeat (89) frame();
    chk("crash_hold", 8'(bus_if.state_o), 8'd4);
    pulse();
    chk("crash_clr", 8'(bus_if.state_o), 8'd1);
    chk("win_keep", 8'(bus_if.winner), 8'h2);
    idle(FGAP - 1);

    // Draw on the tick frame
    to_play();
    idle(FGAP - 1);
    pulse();
    idle(FGAP - 1);
    bus_if.frame_start = 1'b1;
    bus_if.p1_crash = 1'b1;
    bus_if.p2_crash = 1'b1;
    cyc();
    bus_if.frame_start = 1'b0;
    bus_if.p1_crash = 1'b0;
    bus_if.p2_crash = 1'b0;
    chk("draw_notick", 8'(bus_if.move_tick), 8'd0);
    chk("draw_st", 8'(bus_if.state_o), 8'd4);
    chk("draw_win", 8'(bus_if.winner), 8'h3);
    chk("draw_p1s", 8'(bus_if.p1_score), 8'd0);
    chk("draw_p2s", 8'(bus_if.p2_score), 8'd1);
    idle(FGAP - 1);
    repeat (89) frame();
    pulse();
    chk("draw_clr", 8'(bus_if.state_o), 8'd1);
    idle(FGAP - 1);

    // p2 wins the match
    for (int i = 0; i < 4; i++) begin
      exp_score = 8'(i + 2);
      exp_state = (i == 3) ? 8'd5 : 8'd1;
      to_play();
      bus_if.p1_crash = 1'b1;
      cyc();
      bus_if.p1_crash = 1'b0;
      chk("round_p2s", 8'(bus_if.p2_score), exp_score);
      idle(FGAP - 1);
      repeat (89) frame();
      pulse();
      chk("round_end", 8'(bus_if.state_o), exp_state);
      idle(FGAP - 1);
    end
    idle(20);
    chk("go_held", 8'(bus_if.state_o), 8'd5);
    chk("go_p2s", 8'(bus_if.p2_score), 8'd5);
    chk("go_win", 8'(bus_if.winner), 8'h2);
    bus_if.start = 1'b0;
    cyc();
    bus_if.start = 1'b1;
    cyc();
    chk("restart_st", 8'(bus_if.state_o), 8'd1);
    chk("restart_p2s", 8'(bus_if.p2_score), 8'd0);
    chk("restart_win", 8'(bus_if.winner), 8'd0);

    // Async reset mid-countdown and mid-clear
    pulse();
    idle(FGAP - 1);
    pulse();
    chk("cd_again", 8'(bus_if.count_digit), 8'd3);
    idle(FGAP - 1);
    repeat (10) frame();
    reset = 1'b1;
    #1;
    chk("arst_st", 8'(bus_if.state_o), 8'd0);
    chk("arst_digit", 8'(bus_if.count_digit), 8'd0);
    reset = 1'b0;
    cyc();
    bus_if.start = 1'b0;
    cyc();
    bus_if.start = 1'b1;
    cyc();
    pulse();
    chk("clr_hi2", 8'(bus_if.clear_trace), 8'd1);
    reset = 1'b1;
    #1;
    chk("arst_clr", 8'(bus_if.clear_trace), 8'd0);
    chk("arst_st2", 8'(bus_if.state_o), 8'd0);
    reset = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
